// File: rtl/mem_bridge.sv
// mem_bridge: decodes the multicycle core's data bus. RAM accesses pass
// through to external memory. A 16-byte MMIO window at the top of the address
// space holds a console TX FIFO, a status/control register and a free-running
// cycle counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   dataadr    CPU byte address
//   writedata  CPU store data
//   memwrite   CPU write strobe (one cycle per store)
//   readdata   combinational read data back to the CPU
//   ram_adr    RAM address (= dataadr)
//   ram_wd     RAM write data (= writedata)
//   ram_we     RAM write enable (never asserted for MMIO)
//   ram_rd     RAM combinational read data
//   tx_data    FIFO head byte
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts the head byte
//   tx_ovf     sticky overflow flag
//
// MMIO map (dataadr[3:2]): 0 TX data (write-only, reads 0), 1 status/control,
// 2 cycle counter, 3 reserved (reads 0, writes ignored).
// Status word: bit0 empty, bit1 full, bit2 tx_ovf, bits[15:8] occupancy.

module mem_bridge #(
  parameter int          N          = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] TX_ADDR    = 32'hFFFF_FFF0,
  parameter logic [31:0] STAT_ADDR  = 32'hFFFF_FFF4,
  parameter logic [31:0] CNT_ADDR   = 32'hFFFF_FFF8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] dataadr,
  input  logic [N-1:0] writedata,
  input  logic         memwrite,
  output logic [N-1:0] readdata,
  output logic [N-1:0] ram_adr,
  output logic [N-1:0] ram_wd,
  output logic         ram_we,
  input  logic [N-1:0] ram_rd,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [N-1:0]  cycle_cnt;
  logic          ovf_q;

  logic          mmio;
  logic          sel_tx;
  logic          sel_stat;
  logic          sel_cnt;
  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  logic          empty;
  logic          stat_clr;
  logic          cnt_load;
  logic [7:0]    occ;
  logic [N-1:0]  status;

  // Byte offset within a word is meaningless for the word-wide registers.
  logic unused_lsb;
  assign unused_lsb = ^dataadr[1:0];

  assign mmio     = (dataadr[N-1:4] == TX_ADDR[N-1:4]);
  assign sel_tx   = (dataadr[3:2] == TX_ADDR[3:2]);
  assign sel_stat = (dataadr[3:2] == STAT_ADDR[3:2]);
  assign sel_cnt  = (dataadr[3:2] == CNT_ADDR[3:2]);

  assign ram_adr = dataadr;
  assign ram_wd  = writedata;
  assign ram_we  = memwrite & ~mmio;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign tx_valid = ~empty;
  assign tx_data  = mem[rd_ptr];
  assign tx_ovf   = ovf_q;

  assign push     = memwrite & mmio & sel_tx;
  assign pop      = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then; when full, wr_ptr == rd_ptr and the head byte is
  // read out before the edge overwrites its slot.
  assign accept   = push & (~full | pop);
  assign stat_clr = memwrite & mmio & sel_stat & writedata[2];
  assign cnt_load = memwrite & mmio & sel_cnt;

  assign occ    = 8'(count);
  assign status = {{(N-16){1'b0}}, occ, 5'b0, ovf_q, full, empty};

  always_comb begin
    readdata = '0;
    if (!mmio)
      readdata = ram_rd;
    else if (sel_stat)
      readdata = status;
    else if (sel_cnt)
      readdata = cycle_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= writedata[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Set wins over clear.
      if (push & full & ~pop)
        ovf_q <= 1'b1;
      else if (stat_clr)
        ovf_q <= 1'b0;

      if (cnt_load)
        cycle_cnt <= writedata;
      else
        cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  localparam int N = 32;
  localparam int D = 8;
  localparam logic [31:0] TX   = 32'hFFFF_FFF0;
  localparam logic [31:0] STAT = 32'hFFFF_FFF4;
  localparam logic [31:0] CNT  = 32'hFFFF_FFF8;
  localparam logic [31:0] RSV  = 32'hFFFF_FFFC;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] dataadr;
  logic [N-1:0] writedata;
  logic         memwrite;
  logic [N-1:0] readdata;
  logic [N-1:0] ram_adr;
  logic [N-1:0] ram_wd;
  logic         ram_we;
  logic [N-1:0] ram_rd;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue, sticky flag, counter value.
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic [31:0] m_cnt;

  mem_bridge #(.N(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .dataadr(dataadr), .writedata(writedata),
    .memwrite(memwrite), .readdata(readdata), .ram_adr(ram_adr),
    .ram_wd(ram_wd), .ram_we(ram_we), .ram_rd(ram_rd), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_ovf(tx_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_status();
    int sz = m_q.size();
    return (sz << 8) | (int'(m_ovf) << 2) | ((sz == D) ? 2 : 0) | ((sz == 0) ? 1 : 0);
  endfunction

  function automatic logic [31:0] m_readdata();
    if (dataadr[31:4] != 28'hFFF_FFFF) return ram_rd;
    case (dataadr[3:2])
      2'd1:    return m_status();
      2'd2:    return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge; the model takes the pre-edge inputs, then outputs settle.
  task automatic tick();
    bit mmio = (dataadr[31:4] == 28'hFFF_FFFF);
    bit pop  = (m_q.size() > 0) && tx_ready;
    bit push = memwrite && mmio && (dataadr[3:2] == 2'd0);
    bit full = (m_q.size() == D);
    if (!reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cnt = 32'h0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full || pop) m_q.push_back(writedata[7:0]);
        else m_ovf = 1'b1;
      end else if (memwrite && mmio && dataadr[3:2] == 2'd1 && writedata[2])
        m_ovf = 1'b0;
      if (memwrite && mmio && dataadr[3:2] == 2'd2) m_cnt = writedata;
      else m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] adr);
    memwrite = 1'b0;
    dataadr  = adr;
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] wd);
    dataadr = adr; writedata = wd; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; memwrite = 1'b0; tx_ready = 1'b0;
    dataadr = 32'h0; writedata = 32'h0; ram_rd = 32'h0;
    tick(); tick();
    idle(CNT);
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_cnt actual=%h required=%h", readdata, 32'h0);
    end
    checks++;
    if (tx_valid !== 1'b0 || tx_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_flags actual=%b%b required=00", tx_valid, tx_ovf);
    end
    reset = 1'b1;
    idle(STAT);
    checks++;
    if (readdata !== 32'h1) begin
      errors++; $display("FAIL reset_stat actual=%h required=%h", readdata, 32'h1);
    end
  endtask

  task automatic test_ram();
    dataadr = 32'h40; writedata = 32'h1234_5678; memwrite = 1'b1;
    ram_rd = 32'hCAFE_F00D;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_adr !== 32'h40 || ram_wd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ram_store actual=%b/%h/%h required=1/00000040/12345678", ram_we, ram_adr, ram_wd);
    end
    tick();
    memwrite = 1'b0; #1;
    checks++;
    if (readdata !== 32'hCAFE_F00D || ram_we !== 1'b0) begin
      errors++; $display("FAIL ram_load actual=%h/%b required=cafef00d/0", readdata, ram_we);
    end
    dataadr = TX; memwrite = 1'b1; writedata = 32'h0; #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++; $display("FAIL mmio_no_ram_we actual=%b required=0", ram_we);
    end
    // Drop the write: drive it to the reserved slot instead.
    dataadr = RSV;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_burst();
    tx_ready = 1'b0;
    dataadr = TX; writedata = 32'h41; memwrite = 1'b1; #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL no_bypass actual=%b required=0", tx_valid);
    end
    tick();
    store(TX, 32'h42);
    store(TX, 32'h43);
    idle(STAT);
    checks++;
    if (readdata !== 32'h0000_0300) begin
      errors++; $display("FAIL burst_stat actual=%h required=%h", readdata, 32'h300);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL burst_drain[%0d] actual=%b/%h required=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0 || readdata !== 32'h1) begin
      errors++; $display("FAIL burst_empty actual=%b/%h required=0/00000001", tx_valid, readdata);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(TX, 32'(i));
    idle(STAT);
    checks++;
    if (readdata !== 32'h0000_0806 || tx_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_stat actual=%h/%b required=00000806/1", readdata, tx_ovf);
    end
    store(STAT, 32'h0);
    idle(STAT);
    checks++;
    if (readdata !== 32'h0000_0806) begin
      errors++; $display("FAIL ovf_noclear actual=%h required=%h", readdata, 32'h806);
    end
    store(STAT, 32'h4);
    idle(STAT);
    checks++;
    if (readdata !== 32'h0000_0802) begin
      errors++; $display("FAIL ovf_clear actual=%h required=%h", readdata, 32'h802);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d] actual=%b/%h required=1/%h", i, tx_valid, tx_data, 8'(i));
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_empty actual=%b required=0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp[$];
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(TX, 32'(8'h10 + i));
    tx_ready = 1'b1;
    store(TX, 32'h99);
    idle(STAT);
    checks++;
    if (readdata !== 32'h0000_0802 || tx_ovf !== 1'b0) begin
      errors++; $display("FAIL full_pop_stat actual=%h/%b required=00000802/0", readdata, tx_ovf);
    end
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
    foreach (exp[i]) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        errors++; $display("FAIL full_pop_drain[%0d] actual=%b/%h required=1/%h", i, tx_valid, tx_data, exp[i]);
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_empty actual=%b required=0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] exp[3];
    exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    store(CNT, 32'hFFFF_FFFE);
    idle(CNT);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (readdata !== exp[i]) begin
        errors++; $display("FAIL counter[%0d] actual=%h required=%h", i, readdata, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(TX, 32'(8'hA0 + i));
    for (int i = 0; i < 6; i++) begin
      tx_ready = (i % 2 == 0);
      tick();
    end
    idle(STAT);
    checks++;
    if (readdata !== 32'h0000_0504) begin
      errors++; $display("FAIL predrain_stat actual=%h required=%h", readdata, 32'h504);
    end
    tx_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle(STAT);
    checks++;
    if (tx_valid !== 1'b0 || tx_ovf !== 1'b0 || readdata !== 32'h1) begin
      errors++;
      $display("FAIL reset_drain actual=%b/%b/%h required=0/0/00000001", tx_valid, tx_ovf, readdata);
    end
    idle(CNT);
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_drain_cnt actual=%h required=%h", readdata, 32'h0);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e_rd;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0, 1:    dataadr = $urandom() & 32'h7FFF_FFFF;
        2, 3, 4: dataadr = TX | $urandom_range(0, 3);
        5, 6:    dataadr = STAT | $urandom_range(0, 3);
        7:       dataadr = CNT | $urandom_range(0, 3);
        default: dataadr = RSV | $urandom_range(0, 3);
      endcase
      writedata = $urandom();
      memwrite  = ($urandom_range(0, 1) == 1);
      ram_rd    = $urandom();
      tx_ready  = ($urandom_range(0, 9) < 4);
      reset     = ($urandom_range(0, 99) != 0);
      #1;
      e_rd = m_readdata();
      checks++;
      if (readdata !== e_rd) begin
        errors++; $display("FAIL rnd_readdata[%0d] adr=%h actual=%h required=%h", c, dataadr, readdata, e_rd);
      end
      checks++;
      if (ram_we !== (memwrite && dataadr[31:4] != 28'hFFF_FFFF)) begin
        errors++; $display("FAIL rnd_ram_we[%0d] actual=%b required=%b", c, ram_we, !ram_we);
      end
      checks++;
      if (tx_valid !== (m_q.size() > 0) || tx_ovf !== m_ovf) begin
        errors++;
        $display("FAIL rnd_flags[%0d] actual=%b/%b required=%b/%b", c, tx_valid, tx_ovf, m_q.size() > 0, m_ovf);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (tx_data !== m_q[0]) begin
          errors++; $display("FAIL rnd_tx_data[%0d] actual=%h required=%h", c, tx_data, m_q[0]);
        end
      end
      tick();
    end
    reset = 1'b1; memwrite = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_burst();
    test_overflow();
    test_full_pop();
    test_counter();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
